// File: rtl/sha256_core.sv
// Iterative SHA-256 compression engine, UNROLL (1/2/4) rounds per clock, multi-block chaining.
// Define SHA256_MIDSTATE_EN to add the midstate_in_i/use_mid_i chaining-value override.
module sha256_core #(
   parameter int UNROLL = 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic         init_i,
   input  logic [511:0] block_in_i,
`ifdef SHA256_MIDSTATE_EN
   input  logic [255:0] midstate_in_i,
   input  logic         use_mid_i,
`endif
   output logic         busy_o,
   output logic         done_o,
   output logic [255:0] hash_out_o
);

   generate
      if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
         $error("sha256_core: UNROLL must be 1, 2 or 4");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ROUND = 2'd1, S_FINAL = 2'd2} state_t;

   localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [5:0]   LAST_CNT = 6'(64 - UNROLL);
   // K0 occupies the top word; entry t sits at bits [2047-32t -: 32].
   localparam logic [2047:0] K_ROM = {
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
   endfunction

   state_t        state_q, state_d;
   logic [5:0]    cnt_q, cnt_d;
   logic [511:0]  w_q, w_d, w_rnd_s;       // W[t] is always the top word of the window
   logic [255:0]  st_q, st_d, st_rnd_s;    // working registers {a..h}
   logic [255:0]  h_q, h_d;
   logic [255:0]  hash_q, hash_d;
   logic [255:0]  chain_s;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   // Chaining value presented with start: midstate (if built in), IV, or last digest.
   always_comb begin
      chain_s = hash_q;
`ifdef SHA256_MIDSTATE_EN
      if (use_mid_i) begin
         chain_s = midstate_in_i;
      end else if (init_i) begin
         chain_s = IV;
      end else begin
         chain_s = hash_q;
      end
`else
      if (init_i) begin
         chain_s = IV;
      end else begin
         chain_s = hash_q;
      end
`endif
   end

   // UNROLL chained compression rounds plus sliding-window schedule update.
   always_comb begin
      logic [31:0] ra, rb, rc, rd, re, rf, rg, rh, t1, t2, nw;
      {ra, rb, rc, rd, re, rf, rg, rh} = st_q;
      t1 = 32'd0;
      t2 = 32'd0;
      nw = 32'd0;
      w_rnd_s = w_q;
      st_rnd_s = st_q;
      for (int u = 0; u < UNROLL; u++) begin
         {ra, rb, rc, rd, re, rf, rg, rh} = st_rnd_s;
         t1 = rh + bsig1(re) + ((re & rf) ^ (~re & rg))
              + K_ROM[2047 - 32 * (int'(cnt_q) + u) -: 32] + w_rnd_s[511:480];
         t2 = bsig0(ra) + ((ra & rb) ^ (ra & rc) ^ (rb & rc));
         st_rnd_s = {t1 + t2, ra, rb, rc, rd + t1, re, rf, rg};
         nw = ssig1(w_rnd_s[63:32]) + w_rnd_s[223:192] + ssig0(w_rnd_s[479:448]) + w_rnd_s[511:480];
         w_rnd_s = {w_rnd_s[479:0], nw};
      end
   end

   // Next-state and datapath-load decisions for IDLE/ROUND/FINAL.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      w_d     = w_q;
      st_d    = st_q;
      h_d     = h_q;
      hash_d  = hash_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               w_d     = block_in_i;
               st_d    = chain_s;
               h_d     = chain_s;
               cnt_d   = 6'd0;
               state_d = S_ROUND;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ROUND: begin
            w_d  = w_rnd_s;
            st_d = st_rnd_s;
            if (cnt_q == LAST_CNT) begin
               cnt_d   = 6'd0;
               state_d = S_FINAL;
            end else begin
               cnt_d   = cnt_q + 6'(UNROLL);
               state_d = S_ROUND;
            end
         end
         S_FINAL: begin
            for (int i = 0; i < 8; i++) begin
               hash_d[32 * i +: 32] = h_q[32 * i +: 32] + st_q[32 * i +: 32];
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and datapath registers; reset aborts any job and clears the digest.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 6'd0;
         w_q     <= 512'd0;
         st_q    <= 256'd0;
         h_q     <= 256'd0;
         hash_q  <= 256'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         w_q     <= w_d;
         st_q    <= st_d;
         h_q     <= h_d;
         hash_q  <= hash_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign hash_out_o = hash_q;

endmodule

// File: tb/tb_sha256_core.sv
// Self-checking bench for sha256_core: UNROLL 1/2/4 instances against an array-based SHA-256 model.
// Define SHA256_MIDSTATE_EN to also exercise the midstate chaining path.
module tb_sha256_core;

   localparam int UN [3] = '{1, 2, 4};
   localparam logic [255:0] IV      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [511:0] ABC     = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
   localparam logic [511:0] EMPTY   = {32'h80000000, {15{32'h00000000}}};
   localparam logic [511:0] NIST1   = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] NIST2   = {{15{32'h00000000}}, 32'h000001c0};
   localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] D_NIST  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   logic         clk = 1'b0;
   logic         rst;
   logic         start_r [3];
   logic         init_r  [3];
   logic [511:0] blk_r   [3];
   logic [255:0] mid_r   [3];
   logic         use_mid_r [3];
   logic         busy_w  [3];
   logic         done_w  [3];
   logic [255:0] hash_w  [3];
   logic [255:0] model_h [3];
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sha256_core #(.UNROLL(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .start_i(start_r[0]), .init_i(init_r[0]), .block_in_i(blk_r[0]),
`ifdef SHA256_MIDSTATE_EN
      .midstate_in_i(mid_r[0]), .use_mid_i(use_mid_r[0]),
`endif
      .busy_o(busy_w[0]), .done_o(done_w[0]), .hash_out_o(hash_w[0]));

   sha256_core #(.UNROLL(2)) u_dut2 (
      .clk_i(clk), .rst_i(rst), .start_i(start_r[1]), .init_i(init_r[1]), .block_in_i(blk_r[1]),
`ifdef SHA256_MIDSTATE_EN
      .midstate_in_i(mid_r[1]), .use_mid_i(use_mid_r[1]),
`endif
      .busy_o(busy_w[1]), .done_o(done_w[1]), .hash_out_o(hash_w[1]));

   sha256_core #(.UNROLL(4)) u_dut4 (
      .clk_i(clk), .rst_i(rst), .start_i(start_r[2]), .init_i(init_r[2]), .block_in_i(blk_r[2]),
`ifdef SHA256_MIDSTATE_EN
      .midstate_in_i(mid_r[2]), .use_mid_i(use_mid_r[2]),
`endif
      .busy_o(busy_w[2]), .done_o(done_w[2]), .hash_out_o(hash_w[2]));

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Reference: full 64-word schedule array, then 64 rounds on an 8-word working array.
   function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] v [8];
      logic [31:0] t1, t2, s0, s1;
      logic [255:0] r;
      for (int i = 0; i < 16; i++) w[i] = blk[511 - 32 * i -: 32];
      for (int i = 16; i < 64; i++) begin
         s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
         s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
         w[i] = s1 + w[i-7] + s0 + w[i-16];
      end
      for (int i = 0; i < 8; i++) v[i] = hin[255 - 32 * i -: 32];
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
              + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
         t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
              + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) r[255 - 32 * i -: 32] = hin[255 - 32 * i -: 32] + v[i];
      return r;
   endfunction

   task automatic check(input string tag, input int d, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
      end
   endtask

   // Issues a job in the current cycle and returns in its done cycle (ready for a back-to-back start).
   task automatic run_job(input int d, input logic [511:0] blk, input logic ini, input logic mid, input int ign_at);
      logic [255:0] chain, exp_h;
      int cyc, bad_hold;
      chain = ini ? IV : model_h[d];
`ifdef SHA256_MIDSTATE_EN
      if (mid) chain = mid_r[d];
      use_mid_r[d] = mid;
`endif
      exp_h = compress(chain, blk);
      start_r[d] = 1'b1; init_r[d] = ini; blk_r[d] = blk;
      @(posedge clk); #1;
      start_r[d] = 1'b0; init_r[d] = 1'($urandom); blk_r[d] = {16{$urandom}};
`ifdef SHA256_MIDSTATE_EN
      use_mid_r[d] = 1'b0; mid_r[d] = {8{$urandom}};
`endif
      check("busy_after_start", d, 256'(busy_w[d]), 256'(1'b1));
      check("done_single_cycle", d, 256'(done_w[d]), 256'(1'b0));
      cyc = 0; bad_hold = 0;
      while (done_w[d] !== 1'b1 && cyc < 200) begin
         if (cyc == ign_at) begin
            start_r[d] = 1'b1; init_r[d] = 1'b1; blk_r[d] = EMPTY;
         end else begin
            start_r[d] = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
         if (done_w[d] !== 1'b1 && hash_w[d] !== model_h[d]) bad_hold++;
      end
      start_r[d] = 1'b0;
      check("latency", d, 256'(cyc), 256'(64 / UN[d] + 1));
      check("hash_held_during_job", d, 256'(bad_hold), 256'(0));
      check("busy_low_in_done", d, 256'(busy_w[d]), 256'(1'b0));
      check("digest_vs_model", d, hash_w[d], exp_h);
      model_h[d] = exp_h;
   endtask

   initial begin
      int n;
      logic [511:0] rb;
      logic ri;
      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         start_r[d] = 1'b0; init_r[d] = 1'b0; blk_r[d] = 512'd0;
         mid_r[d] = 256'd0; use_mid_r[d] = 1'b0; model_h[d] = 256'd0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int d = 0; d < 3; d++) begin
         check("reset_busy", d, 256'(busy_w[d]), 256'(1'b0));
         check("reset_done", d, 256'(done_w[d]), 256'(1'b0));
         check("reset_hash", d, hash_w[d], 256'd0);
      end

      run_job(0, ABC, 1'b1, 1'b0, -1);
      check("abc_digest", 0, hash_w[0], D_ABC);

      for (int d = 0; d < 3; d++) begin
         run_job(d, EMPTY, 1'b1, 1'b0, -1);
         check("empty_digest", d, hash_w[d], D_EMPTY);
      end

      run_job(0, NIST1, 1'b1, 1'b0, -1);
      run_job(0, NIST2, 1'b0, 1'b0, -1);
      check("nist_two_block", 0, hash_w[0], D_NIST);

      run_job(0, ABC, 1'b1, 1'b0, 20);
      check("abc_with_ignored_start", 0, hash_w[0], D_ABC);
      @(posedge clk); #1;
      check("no_second_done", 0, 256'(done_w[0]), 256'(1'b0));
      check("idle_after_ignored", 0, 256'(busy_w[0]), 256'(1'b0));

      // Abort the abc job so reset is sampled in place of round 40.
      start_r[0] = 1'b1; init_r[0] = 1'b1; blk_r[0] = ABC;
      @(posedge clk); #1;
      start_r[0] = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int d = 0; d < 3; d++) model_h[d] = 256'd0;
      check("abort_busy", 0, 256'(busy_w[0]), 256'(1'b0));
      check("abort_hash", 0, hash_w[0], 256'd0);
      n = 0;
      repeat (80) begin
         @(posedge clk); #1;
         if (done_w[0] === 1'b1) n++;
      end
      check("abort_no_done", 0, 256'(n), 256'(0));
      run_job(0, ABC, 1'b1, 1'b0, -1);
      check("abc_after_abort", 0, hash_w[0], D_ABC);

      for (int d = 0; d < 3; d++) begin
         for (int j = 0; j < 4; j++) begin
            rb = {16{$urandom}};
            for (int k = 0; k < 16; k++) rb[32 * k +: 32] = $urandom;
            ri = (j == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            run_job(d, rb, ri, 1'b0, -1);
         end
      end

`ifdef SHA256_MIDSTATE_EN
      run_job(0, NIST1, 1'b1, 1'b0, -1);
      mid_r[0] = model_h[0];
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int d = 0; d < 3; d++) model_h[d] = 256'd0;
      mid_r[0] = compress(IV, NIST1);
      run_job(0, NIST2, 1'b1, 1'b1, -1);
      check("midstate_digest", 0, hash_w[0], D_NIST);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sha256_core.md
# sha256_core

Iterative SHA-256 compression engine. It processes one 512-bit message block per job and produces the 256-bit chaining value, executing `UNROLL` rounds per clock. It sits between the block/padding front end and the mining/hash-compare logic, and supersedes the fixed, unfinished round-constant holder. It adds multi-block chaining, a start/done handshake, synchronous reset and configurable unrolling.

## Interface
Parameters:
- `UNROLL`, default 1: rounds per clock. Legal values are 1, 2 and 4; any other value fails elaboration.

Ports:
- `clk` in 1: single clock. All logic is clocked on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a job. Sampled only while `busy`=0.
- `init` in 1: sampled with `start`. 1 = chain from the standard IV; 0 = chain from the current `hash_out`.
- `block_in` in 512: message block, big-endian words. `[511:480]`=W0 … `[31:0]`=W15. Sampled with `start`.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle pulse when `hash_out` is updated.
- `hash_out` out 256: chaining value. `[255:224]`=H0 … `[31:0]`=H7. Held until the next job completes.
- `midstate_in` in 256, present only with `SHA256_MIDSTATE_EN`: external chaining value, same word order as `hash_out`.
- `use_mid` in 1, present only with `SHA256_MIDSTATE_EN`: sampled with `start`. Selects `midstate_in` as the chaining value and overrides `init`.

## Operation
- Reset values: `busy`=0, `done`=0, `hash_out`=0, state IDLE, round counter 0.
- FSM states:
  - IDLE: on `start`, latch `block_in` into the 16-word schedule window. Latch the chaining value (IV, `hash_out`, or `midstate_in`) into H0..H7 and working registers a..h. Go to ROUND.
  - ROUND: each cycle, perform `UNROLL` standard SHA-256 rounds. Use the internal 64-entry K ROM (FIPS 180-4 constants, K0=428a2f98, K63=c67178f2) and schedule words Wt. For t≥16, Wt = σ1(Wt-2) + Wt-7 + σ0(Wt-15) + Wt-16, computed in a sliding 16-word window. The counter advances by `UNROLL`. After round 63, go to FINAL.
  - FINAL: Hi ← Hi + working register i for i = 0..7; load the result into `hash_out`; pulse `done`; go to IDLE.
- Arithmetic: all additions are modulo 2^32 and carries are discarded. Rotates and shifts follow FIPS 180-4 Σ0, Σ1, σ0, σ1, Ch and Maj.
- Multi-block messages: the first block uses `init`=1; each later block uses `init`=0. Padding is the caller's responsibility.
- `start` while `busy`=1 is ignored; no queuing.
- `rst` during ROUND or FINAL aborts the job: no `done`, `hash_out` is cleared to 0, state returns to IDLE.
- Inputs are don't-care outside the `start` cycle. A `block_in` change during a job has no effect.

## Timing
- `start` is sampled at edge N. `busy`=1 from N+1.
- Rounds occupy edges N+1 … N+R, where R = 64/`UNROLL` (64, 32 or 16).
- Edge N+R+1 performs FINAL. `hash_out` is valid and `done`=1 for exactly the cycle after that edge, and `busy` returns to 0 on the same edge.
- Latency from `start` to `done` is R+1 cycles: 65, 33 or 17.
- Back-to-back jobs: `start` is accepted in the `done` cycle. The new job's `init`=0 chains from the `hash_out` value just produced.
- `rst` has priority over `start` when both are asserted.

## Configuration
- `SHA256_MIDSTATE_EN` defined: the `midstate_in` and `use_mid` ports exist. With `use_mid`=1 at `start`, chaining begins from `midstate_in`. This supports Bitcoin header second-block hashing from a precomputed midstate.
- `SHA256_MIDSTATE_EN` undefined: the ports are omitted, and the chaining value is IV or `hash_out` only.
- Timing is identical in both builds.

## Test plan
- Reset, then "abc" (`block_in` = 61626380, 14×00000000, 00000018) with `init`=1 and `UNROLL`=1:
  - `done` 65 cycles after `start`.
  - `hash_out` = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Empty message (80000000, 15×0) with `init`=1, at `UNROLL` = 1, 2 and 4:
  - `hash_out` = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
  - Latency 65, 33 and 17 cycles respectively.
- 448-bit NIST message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - Block 1 with `init`=1, then block 2 with `init`=0, issued in block 1's `done` cycle.
  - Final `hash_out` = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- `start` pulsed while `busy`=1 at round 20:
  - Ignored.
  - Exactly one `done`, and the "abc" digest is unchanged.
- `rst` asserted at round 40 of the "abc" job:
  - Next cycle: `busy`=0, `hash_out`=0.
  - No `done` pulse.
  - A new "abc" job then yields the correct digest.
- With `SHA256_MIDSTATE_EN`:
  - Run block 1 of the NIST message and capture its `hash_out` as `midstate_in`.
  - Reset, then run block 2 with `use_mid`=1.
  - Result is 248d6a61…db06c1.
